// File: rtl/conv1d_stream_relu.sv
// conv1d_stream_relu: streaming 1-D convolution with runtime filter, stride, saturating MAC and optional ReLU
module conv1d_stream_relu #(
    parameter int T    = 16,
    parameter int X    = 16,
    parameter int F    = 4,
    parameter int S    = 1,
    parameter int RELU = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [T-1:0] f_data,
    input  logic         f_valid,
    output logic         f_ready,
    input  logic [T-1:0] x_data,
    input  logic         x_valid,
    output logic         x_ready,
    output logic [T-1:0] y_data,
    output logic         y_valid,
    input  logic         y_ready
);
    localparam int AW = $clog2(X);
    localparam int TW = $clog2(F);
    localparam int CW = $clog2(F + 3);
    localparam logic [AW-1:0] LAST_B = AW'(X - F);
    localparam logic signed [T-1:0] SMAX = {1'b0, {(T-1){1'b1}}};
    localparam logic signed [T-1:0] SMIN = {1'b1, {(T-1){1'b0}}};

    if (F < 2 || F > X || S < 1 || (X - F) % S != 0) begin : g_bad_params
        $error("conv1d_stream_relu: need 2 <= F <= X, S >= 1 and (X-F) divisible by S");
    end

    typedef enum logic [1:0] {LOADF, LOADX, COMPUTE, OUTPUT} state_t;
    state_t state, state_nx;

    logic [TW-1:0] fcnt;
    logic [AW-1:0] xcnt, b, addr;
    logic [CW-1:0] cnt;
    logic signed [T-1:0] taps [F];
    logic signed [T-1:0] mem [X];
    logic signed [T-1:0] rd_data, tap_q, prod, acc, mul_sat, sum_sat;
    logic signed [2*T-1:0] mul;
    logic signed [T:0] sum;
    logic rd_v, p_v;
    logic f_hs, x_hs, y_hs, f_last, x_last, issue, done, start;

    assign f_hs    = f_valid && f_ready;
    assign x_hs    = x_valid && x_ready;
    assign y_hs    = y_valid && y_ready;
    assign f_last  = fcnt == TW'(F - 1);
    assign x_last  = xcnt == AW'(X - 1);
    assign issue   = state == COMPUTE && cnt < CW'(F);
    assign done    = state == COMPUTE && cnt == CW'(F + 2);
    assign start   = state_nx == COMPUTE && state != COMPUTE;
    assign addr    = b + AW'(cnt);
    assign mul     = rd_data * tap_q;
    assign mul_sat = (&mul[2*T-1:T-1] || ~|mul[2*T-1:T-1]) ? mul[T-1:0] : (mul[2*T-1] ? SMIN : SMAX);
    assign sum     = {acc[T-1], acc} + {prod[T-1], prod};
    assign sum_sat = (sum[T] == sum[T-1]) ? sum[T-1:0] : (sum[T] ? SMIN : SMAX);

    // state register; reset forces LOADF, which also invalidates the stored filter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= LOADF;
        else          state <= state_nx;
    end

    // next state and handshake outputs, all gated by reset so nothing is offered during reset
    always_comb begin
        state_nx = state;
        f_ready  = 1'b0;
        x_ready  = 1'b0;
        y_valid  = 1'b0;
        unique case (state)
            LOADF: begin
                f_ready  = reset_n;
                state_nx = (f_hs && f_last) ? LOADX : LOADF;
            end
            LOADX: begin
                x_ready  = reset_n;
                state_nx = (x_hs && x_last) ? COMPUTE : LOADX;
            end
            COMPUTE: state_nx = done ? OUTPUT : COMPUTE;
            OUTPUT: begin
                y_valid  = reset_n;
                state_nx = y_hs ? (b == LAST_B ? LOADX : COMPUTE) : OUTPUT;
            end
        endcase
    end

    // counters, window base and the read -> product -> accumulate -> output pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt    <= '0;
            xcnt    <= '0;
            cnt     <= '0;
            b       <= '0;
            rd_v    <= 1'b0;
            p_v     <= 1'b0;
            rd_data <= '0;
            tap_q   <= '0;
            prod    <= '0;
            acc     <= '0;
            y_data  <= '0;
        end else begin
            if (f_hs) fcnt <= f_last ? '0 : fcnt + TW'(1);
            if (x_hs) xcnt <= x_last ? '0 : xcnt + AW'(1);
            cnt  <= state == COMPUTE ? cnt + CW'(1) : '0;
            rd_v <= issue;
            p_v  <= rd_v;
            if (issue) begin
                rd_data <= mem[addr];
                tap_q   <= taps[TW'(cnt)];
            end
            prod <= mul_sat;
            if (start)    acc <= '0;
            else if (p_v) acc <= sum_sat;
            if (done) y_data <= (RELU != 0 && acc[T-1]) ? '0 : acc;
            if (x_hs && x_last) b <= '0;
            else if (y_hs)      b <= b == LAST_B ? '0 : b + AW'(S);
        end
    end

    // tap register file and sample buffer need no reset; the FSM decides when they are valid
    always_ff @(posedge clk) begin
        if (f_hs) taps[fcnt] <= f_data;
        if (x_hs) mem[xcnt] <= x_data;
    end
endmodule

// File: tb/tb_conv1d_stream_relu.sv
// tb_conv1d_stream_relu: table-driven scoreboard bench for two conv1d_stream_relu configurations
module tb_conv1d_stream_relu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rn [2];
    logic signed [15:0] f_data [2];
    logic signed [15:0] x_data [2];
    logic signed [15:0] y_data [2];
    logic f_valid [2], f_ready [2], x_valid [2], x_ready [2], y_valid [2], y_ready [2];
    int total = 0;
    int bad = 0;
    int q0 [$];
    int q1 [$];

    typedef struct {
        int d;
        bit lf;
        bit g;
        logic [3:0][15:0] tp;
        int x0;
        int xs;
        int first;
        int step;
    } tc_t;
    tc_t tcs [10];

    conv1d_stream_relu #(.T(16), .X(16), .F(4), .S(1), .RELU(1)) u0 (
        .clk(clk), .reset_n(rn[0]),
        .f_data(f_data[0]), .f_valid(f_valid[0]), .f_ready(f_ready[0]),
        .x_data(x_data[0]), .x_valid(x_valid[0]), .x_ready(x_ready[0]),
        .y_data(y_data[0]), .y_valid(y_valid[0]), .y_ready(y_ready[0])
    );

    conv1d_stream_relu #(.T(16), .X(16), .F(4), .S(2), .RELU(0)) u1 (
        .clk(clk), .reset_n(rn[1]),
        .f_data(f_data[1]), .f_valid(f_valid[1]), .f_ready(f_ready[1]),
        .x_data(x_data[1]), .x_valid(x_valid[1]), .x_ready(x_ready[1]),
        .y_data(y_data[1]), .y_valid(y_valid[1]), .y_ready(y_ready[1])
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return d == 0 ? q0.size() : q1.size();
    endfunction

    task automatic push(input int d, input int v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic pop_check(input int d, input int v);
        int e;
        if (qsize(d) == 0) begin
            total++;
            bad++;
            $display("FAIL y_unexpected dut%0d: got %0d expected no output", d, v);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("y_dut%0d", d), v, e);
    endtask

    // outputs are sampled on the falling edge, ahead of the rising edge that completes the handshake
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if ((f_ready[d] && x_ready[d]) || (y_valid[d] && (f_ready[d] || x_ready[d]))) begin
                bad++;
                $display("FAIL ready_exclusive dut%0d: f_ready=%0d x_ready=%0d y_valid=%0d", d, f_ready[d], x_ready[d], y_valid[d]);
            end
            if (y_valid[d] && y_ready[d]) pop_check(d, y_data[d]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input int d);
        rn[d] = 1'b0;
        f_valid[d] = 1'b0;
        x_valid[d] = 1'b0;
        #1;
        check($sformatf("rst_handshakes_dut%0d", d), int'({f_ready[d], x_ready[d], y_valid[d]}), 0);
        check($sformatf("rst_ydata_dut%0d", d), y_data[d], 0);
        if (d == 0) q0.delete();
        else        q1.delete();
        tick();
        tick();
        rn[d] = 1'b1;
        #1;
        check($sformatf("rst_release_fready_dut%0d", d), f_ready[d], 1);
        tick();
    endtask

    task automatic send(input int d, input bit is_x, input int v, input bit g);
        int n = 0;
        bit hs = 1'b0;
        if (g) repeat ($urandom_range(0, 3)) tick();
        if (is_x) begin
            x_data[d] = 16'(v);
            x_valid[d] = 1'b1;
        end else begin
            f_data[d] = 16'(v);
            f_valid[d] = 1'b1;
        end
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = is_x ? x_ready[d] : f_ready[d];
            tick();
            n++;
        end
        x_valid[d] = 1'b0;
        f_valid[d] = 1'b0;
        if (!hs) begin
            bad++;
            $display("FAIL %s_timeout dut%0d: no ready within 100 cycles", is_x ? "x" : "f", d);
        end
    endtask

    task automatic load_taps(input int d, input logic [3:0][15:0] tp, input bit g);
        for (int k = 0; k < 4; k++) send(d, 1'b0, int'(tp[k]), g);
    endtask

    task automatic send_vec(input int d, input int x0, input int xs, input bit g);
        for (int k = 0; k < 16; k++) send(d, 1'b1, x0 + k * xs, g);
    endtask

    task automatic wait_q(input int d, input int target, input int bound);
        int n = 0;
        while (qsize(d) > target && n < bound) begin
            tick();
            n++;
        end
        if (qsize(d) > target) begin
            bad++;
            $display("FAIL wait_outputs dut%0d: %0d outputs still pending after %0d cycles", d, qsize(d), bound);
        end
    endtask

    task automatic measure(input int d, input string name, input int exp);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            seen = y_valid[d];
            if (!seen) begin
                tick();
                n++;
            end
        end
        tick();
        check(name, n, exp);
    endtask

    function automatic tc_t mk(input int d, input bit lf, input bit g, input int t0, input int t1,
                               input int t2, input int t3, input int x0, input int xs,
                               input int first, input int step);
        tc_t r;
        r.d = d;
        r.lf = lf;
        r.g = g;
        r.tp[0] = 16'(t0);
        r.tp[1] = 16'(t1);
        r.tp[2] = 16'(t2);
        r.tp[3] = 16'(t3);
        r.x0 = x0;
        r.xs = xs;
        r.first = first;
        r.step = step;
        return r;
    endfunction

    task automatic run_case(input int i);
        tc_t c = tcs[i];
        int n = c.d == 0 ? 13 : 7;
        if (c.lf) begin
            reset_dut(c.d);
            load_taps(c.d, c.tp, c.g);
        end
        for (int k = 0; k < n; k++) push(c.d, c.first + k * c.step);
        send_vec(c.d, c.x0, c.xs, c.g);
        wait_q(c.d, 0, 400);
        check($sformatf("x_ready_after_last_case%0d", i), x_ready[c.d], 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rn[d] = 1'b0;
            f_valid[d] = 1'b0;
            x_valid[d] = 1'b0;
            f_data[d] = '0;
            x_data[d] = '0;
            y_ready[d] = 1'b1;
        end
        tcs[0] = mk(0, 1, 0, 1, 2, 3, 4, 0, 1, 20, 10);
        tcs[1] = mk(1, 1, 0, 1, 2, 3, 4, 0, 1, 20, 20);
        tcs[2] = mk(1, 0, 1, 1, 2, 3, 4, 0, 1, 20, 20);
        tcs[3] = mk(0, 1, 1, 1, 2, 3, 4, 0, 1, 20, 10);
        tcs[4] = mk(0, 1, 0, 32767, 32767, 32767, 32767, 32767, 0, 32767, 0);
        tcs[5] = mk(1, 1, 0, -32768, -32768, -32768, -32768, 32767, 0, -32768, 0);
        tcs[6] = mk(0, 1, 0, -1, -1, -1, -1, 5, 0, 0, 0);
        tcs[7] = mk(1, 1, 0, -1, -1, -1, -1, 5, 0, -20, 0);
        tcs[8] = mk(1, 1, 0, 32767, 32767, -32768, 1, 2, 0, 1, 0);
        tcs[9] = mk(1, 1, 0, 32767, 32767, -32768, -32768, 2, 0, -32768, 0);
        tick();
        tick();
        for (int i = 0; i < 10; i++) run_case(i);

        reset_dut(0);
        load_taps(0, tcs[0].tp, 1'b0);
        y_ready[0] = 1'b0;
        send_vec(0, 0, 1, 1'b0);
        measure(0, "latency_last_x", 7);
        repeat (10) begin
            check("backpressure_valid", y_valid[0], 1);
            check("backpressure_data", y_data[0], 20);
            tick();
        end
        for (int k = 0; k < 13; k++) push(0, 20 + 10 * k);
        y_ready[0] = 1'b1;
        tick();
        y_ready[0] = 1'b0;
        measure(0, "latency_after_y", 7);
        y_ready[0] = 1'b1;
        wait_q(0, 0, 400);
        check("x_ready_after_backpressure", x_ready[0], 1);

        reset_dut(0);
        load_taps(0, tcs[0].tp, 1'b0);
        for (int k = 0; k < 13; k++) push(0, 20 + 10 * k);
        send_vec(0, 0, 1, 1'b0);
        wait_q(0, 9, 400);
        tick();
        tick();
        reset_dut(0);
        repeat (10) begin
            check("post_reset_no_y_valid", y_valid[0], 0);
            tick();
        end
        run_case(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
